hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard sequencer for the 5-stage core, paired with the forwarding unit in the ID/EX boundary logic.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Issues multi-cycle multiply/divide operations and stalls dependent instructions until the result is ready.
- Flushes wrong-path instructions on taken branches.
- Keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MDU_LATENCY, 32, cycles from mdu_start to HI/LO valid; legal range 1..(2^CNT_W - 1)
- CNT_W, 6, width of the MDU countdown counter
- STALL_W, 32, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous and active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_is_mdu  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  destination register of the EX instruction
- branch_taken  in  1  branch/jump resolved taken this cycle
- pc_wen  out  1  PC write enable
- if_id_wen  out  1  IF/ID register write enable
- if_id_flush  out  1  clear IF/ID to a NOP
- id_ex_flush  out  1  clear ID/EX to a NOP (bubble)
- mdu_start  out  1  one-cycle pulse that launches the MDU
- mdu_busy  out  1  MDU result not yet valid
- stall_cycles  out  STALL_W  saturating count of stall cycles

## Operation
Hazard terms:
- load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))
- mdu_haz = (state == MDU_BUSY) & (id_is_mdu | id_reads_hilo)

Per-cycle priority, highest first:
- rst: pc_wen=0, if_id_wen=0, if_id_flush=1, id_ex_flush=1, mdu_start=0.
- branch_taken: pc_wen=1, if_id_wen=1, if_id_flush=1, id_ex_flush=1.
  - Stalls are ignored this cycle.
  - No mdu_start, because the ID instruction is on the wrong path.
  - An MDU operation already in flight continues.
- load_use or mdu_haz: pc_wen=0, if_id_wen=0, id_ex_flush=1, if_id_flush=0.
- RUN & id_is_mdu: mdu_start=1; pipeline advances.
- Otherwise: pc_wen=1, if_id_wen=1, both flushes 0, mdu_start=0.

State machine:
- RUN: on mdu_start, cnt <= MDU_LATENCY, state <= MDU_BUSY.
- MDU_BUSY: cnt decrements every cycle. When cnt == 1 at the clock edge, state <= RUN and cnt <= 0.
- mdu_busy = (state == MDU_BUSY).

stall_cycles:
- Increments on each cycle where load_use or mdu_haz is the winning action, i.e. not overridden by branch_taken or rst.
- Holds at 2^STALL_W - 1 once it reaches that value.
- Branch flushes are not counted.

## Timing
- All outputs other than state, cnt and stall_cycles are combinational from state and inputs. There is zero-cycle latency from hazard inputs to stall and flush outputs.
- Reset values: state=RUN, cnt=0, stall_cycles=0, mdu_busy=0. Reset takes effect immediately and asynchronously, including mid-MDU; the in-flight operation is abandoned.
- A load-use hazard costs exactly one bubble cycle. The next cycle the load is in MEM and the forwarding unit resolves the dependence.
- mdu_start in cycle T gives mdu_busy high in cycles T+1..T+MDU_LATENCY.
- A dependent MDU or HI/LO instruction held in ID issues at T+MDU_LATENCY+1.
- Non-dependent instructions flow during MDU_BUSY without stalling.
- load_use and mdu_haz in the same cycle produce a single stall and a single stall_cycles increment.
- The MDU_BUSY -> RUN edge takes priority over a new start. A new mdu_start is possible only in RUN, so back-to-back MDU operations have the second issued at T+MDU_LATENCY+1.

## Structure
- Shared package pipeline_pkg holds:
  - the state encoding (RUN, MDU_BUSY)
  - REG_ZERO = 5'd0
  - the default MDU_LATENCY
- The forwarding unit imports REG_ZERO from the same package.
- Sub-module mdu_timer holds the countdown counter and the busy flag.
  - Inputs: start, rst, clk.
  - Outputs: busy, and done, a pulse on the final busy cycle.
- The top level holds hazard decode, priority muxing and stall_cycles.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle of pc_wen=0, if_id_wen=0, id_ex_flush=1; stall_cycles 0 -> 1. Repeat with ex_rt=0 -> no stall.
- rt sensitivity: ex_rt=7, id_rt=7 -> stall when id_uses_rt=1; no stall when id_uses_rt=0.
- MDU dependence: MDU_LATENCY=4, mdu_start at T, mfhi in ID from T+1 -> stall T+1..T+4, issue at T+5; mdu_busy high T+1..T+4; stall_cycles=4.
- Branch priority: branch_taken=1 together with load_use=1 and id_is_mdu=1 in RUN -> both flushes 1, pc_wen=1, mdu_start=0, stall_cycles unchanged.
- Reset mid-operation: assert rst at cycle T+2 of a 32-cycle MDU operation -> mdu_busy=0 immediately; after release, state RUN and stall_cycles=0.
- Saturation: STALL_W=3, 9 consecutive stall cycles -> stall_cycles reads 7.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the 5-stage core's ID/EX boundary logic. Imported by
//   the hazard control unit and the forwarding unit.
//     mdu_state_e          : MDU sequencer state encoding (RUN, MDU_BUSY)
//     REG_ZERO             : architectural zero register index
//     MDU_LATENCY_DEFAULT  : default cycles from mdu_start to HI/LO valid
// ----------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam logic [4:0]  REG_ZERO            = 5'd0;
  localparam int unsigned MDU_LATENCY_DEFAULT = 32;

endpackage : pipeline_pkg

// File: rtl/mdu_timer.sv
// ----------------------------------------------------------------------------
// mdu_timer
//   Tracks an in-flight multiply/divide. A start pulse in RUN loads the
//   countdown with LATENCY; busy then stays high for exactly LATENCY cycles.
//   Ports:
//     clk   in  : pipeline clock
//     rst   in  : asynchronous active-high reset, abandons any operation
//     start in  : launch pulse (only honoured in RUN)
//     busy  out : result not yet valid (state == MDU_BUSY)
//     done  out : high on the final busy cycle
// ----------------------------------------------------------------------------
module mdu_timer
  import pipeline_pkg::*;
#(
  parameter int unsigned LATENCY = MDU_LATENCY_DEFAULT,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (start) begin
          state_d = MDU_BUSY;
          cnt_d   = CNT_W'(LATENCY);
        end
      end
      MDU_BUSY: begin
        // Returning to RUN wins over any start seen this cycle; the top only
        // raises start in RUN, so a back-to-back op issues one cycle later.
        if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == MDU_BUSY);
  assign done = busy && (cnt_q == CNT_W'(1));

endmodule : mdu_timer

// File: rtl/hazard_control_unit.sv
// ----------------------------------------------------------------------------
// hazard_control_unit
//   Pipeline hazard sequencer: one-bubble load-use stall, MDU issue and
//   dependent-instruction stall, wrong-path flush on taken branches, and a
//   saturating stall-cycle counter.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     id_rs, id_rt    : source fields of the ID instruction
//     id_uses_rt      : ID instruction reads rt
//     id_is_mdu       : ID instruction is mult/multu/div/divu
//     id_reads_hilo   : ID instruction is mfhi/mflo
//     ex_mem_read     : EX instruction is a load
//     ex_rt           : EX instruction destination
//     branch_taken    : branch/jump resolved taken this cycle
//     pc_wen          : PC write enable
//     if_id_wen       : IF/ID write enable
//     if_id_flush     : clear IF/ID to NOP
//     id_ex_flush     : clear ID/EX to NOP (bubble)
//     mdu_start       : one-cycle MDU launch pulse
//     mdu_busy        : MDU result not yet valid
//     stall_cycles    : saturating stall-cycle count
// ----------------------------------------------------------------------------
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned STALL_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic               id_is_mdu,
  input  logic               id_reads_hilo,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rt,
  input  logic               branch_taken,
  output logic               pc_wen,
  output logic               if_id_wen,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               mdu_start,
  output logic               mdu_busy,
  output logic [STALL_W-1:0] stall_cycles
);

  logic               load_use;
  logic               mdu_haz;
  logic               stall_win;
  logic               mdu_done;
  logic [STALL_W-1:0] stall_cycles_q, stall_cycles_d;

  mdu_timer #(
    .LATENCY (MDU_LATENCY),
    .CNT_W   (CNT_W)
  ) u_mdu_timer (
    .clk   (clk),
    .rst   (rst),
    .start (mdu_start),
    .busy  (mdu_busy),
    .done  (mdu_done)
  );

  // Hazard decode
  always_comb begin
    load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mdu_haz  = mdu_busy && (id_is_mdu || id_reads_hilo);
  end

  // Priority mux: rst > branch_taken > stall > MDU issue > advance
  always_comb begin
    pc_wen      = 1'b1;
    if_id_wen   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mdu_start   = 1'b0;
    stall_win   = 1'b0;
    if (rst) begin
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use || mdu_haz) begin
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      id_ex_flush = 1'b1;
      stall_win   = 1'b1;
    end else if (!mdu_busy && id_is_mdu) begin
      mdu_start = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_win && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // The final-cycle pulse can only occur while the MDU is busy.
  a_done_in_busy : assert property (@(posedge clk) disable iff (rst)
    mdu_done |-> mdu_busy);

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int unsigned LAT = 4;
  localparam int unsigned SW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rt = 1'b0, id_is_mdu = 1'b0, id_reads_hilo = 1'b0;
  logic          ex_mem_read = 1'b0, branch_taken = 1'b0;
  logic          pc_wen, if_id_wen, if_id_flush, id_ex_flush, mdu_start, mdu_busy;
  logic [SW-1:0] stall_cycles;

  hazard_control_unit #(
    .MDU_LATENCY (LAT),
    .CNT_W       (6),
    .STALL_W     (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_is_mdu     (id_is_mdu),
    .id_reads_hilo (id_reads_hilo),
    .ex_mem_read   (ex_mem_read),
    .ex_rt         (ex_rt),
    .branch_taken  (branch_taken),
    .pc_wen        (pc_wen),
    .if_id_wen     (if_id_wen),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .mdu_start     (mdu_start),
    .mdu_busy      (mdu_busy),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pc_wen;
    logic          if_id_wen;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          mdu_start;
    logic          mdu_busy;
    logic [SW-1:0] stall_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vidx  = 0;

  // Expected-response builders
  function automatic exp_t e_rst();
    return '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0};
  endfunction
  function automatic exp_t e_run(input logic busy, input logic [SW-1:0] c);
    return '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, busy, c};
  endfunction
  function automatic exp_t e_start(input logic [SW-1:0] c);
    return '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c};
  endfunction
  function automatic exp_t e_stall(input logic busy, input logic [SW-1:0] c);
    return '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, busy, c};
  endfunction
  function automatic exp_t e_flush(input logic busy, input logic [SW-1:0] c);
    return '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, busy, c};
  endfunction

  // Apply one input vector just after the rising edge and queue its expectation.
  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mdu, input logic hilo,
                       input logic mr, input logic [4:0] ert, input logic br,
                       input exp_t e);
    @(posedge clk);
    #1;
    rst           = r;
    id_rs         = rs;
    id_rt         = rt;
    id_uses_rt    = urt;
    id_is_mdu     = mdu;
    id_reads_hilo = hilo;
    ex_mem_read   = mr;
    ex_rt         = ert;
    branch_taken  = br;
    exp_q.push_back(e);
    id_q.push_back(vidx);
    vidx++;
  endtask

  task automatic nop(input exp_t e);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, e);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        exp_t a;
        int   id;
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        a  = '{pc_wen, if_id_wen, if_id_flush, id_ex_flush, mdu_start, mdu_busy, stall_cycles};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL vec%0d: got pc=%b ifw=%b iff=%b idf=%b st=%b bz=%b cnt=%0d, want pc=%b ifw=%b iff=%b idf=%b st=%b bz=%b cnt=%0d",
                   id, a.pc_wen, a.if_id_wen, a.if_id_flush, a.id_ex_flush, a.mdu_start,
                   a.mdu_busy, a.stall_cycles, e.pc_wen, e.if_id_wen, e.if_id_flush,
                   e.id_ex_flush, e.mdu_start, e.mdu_busy, e.stall_cycles);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, e_rst());
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, e_rst());
    nop(e_run(1'b0, 3'd0));

    // Load-use on rs: one bubble, counter 0 -> 1; ex_rt = 0 never stalls
    drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, e_stall(1'b0, 3'd0));
    nop(e_run(1'b0, 3'd1));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, e_run(1'b0, 3'd1));
    nop(e_run(1'b0, 3'd1));

    // rt sensitivity gated by id_uses_rt
    drive(1'b0, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, e_stall(1'b0, 3'd1));
    drive(1'b0, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, e_run(1'b0, 3'd2));
    nop(e_run(1'b0, 3'd2));

    // Branch beats load-use and MDU issue; counter unchanged
    drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, e_flush(1'b0, 3'd2));
    nop(e_run(1'b0, 3'd2));

    // Asynchronous reset clears the counter immediately
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, e_rst());

    // MDU dependence: start at T, mfhi stalls T+1..T+4, issues at T+5
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, e_start(3'd0));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, e_stall(1'b1, 3'd0));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, e_stall(1'b1, 3'd1));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, e_stall(1'b1, 3'd2));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, e_stall(1'b1, 3'd3));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, e_run(1'b0, 3'd4));
    nop(e_run(1'b0, 3'd4));

    // Independent flow during busy, branch mid-op, combined hazards, back-to-back MDU
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, e_start(3'd4));
    nop(e_run(1'b1, 3'd4));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, e_flush(1'b1, 3'd4));
    drive(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, e_stall(1'b1, 3'd4));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, e_stall(1'b1, 3'd5));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, e_start(3'd6));
    nop(e_run(1'b1, 3'd6));
    nop(e_run(1'b1, 3'd6));

    // Reset mid-operation abandons the MDU op; afterwards RUN accepts a new start
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, e_rst());
    nop(e_run(1'b0, 3'd0));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, e_start(3'd0));
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, e_rst());

    // Saturation: 9 consecutive load-use stalls with a 3-bit counter
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0,
            e_stall(1'b0, (k > 7) ? 3'd7 : 3'(k)));
    end
    nop(e_run(1'b0, 3'd7));
    nop(e_run(1'b0, 3'd7));

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_hazard_control_unit
